imem_loadable: RTL

//  Parametrised instruction memory for the RISC-V cores: word-addressed ROM-like fetch port plus a

---
 rtl/imem_loadable.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/imem_loadable.sv
// imem_loadable: word-addressed instruction memory with a streaming loader.
// The fetch port is either combinational (REG_OUT=0) or registered (REG_OUT=1).
// The loader FSM writes load_len consecutive words, starting at load_base and
// wrapping modulo DEPTH. While it runs, busy is high and fetches return a NOP.
module imem_loadable #(
    parameter int    DEPTH     = 32,
    parameter int    REG_OUT   = 0,
    parameter int    LEN_W     = 16,
    parameter string INIT_FILE = ""
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic             fetch_req,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             fetch_fault,
    output logic             busy,
    input  logic             load_start,
    input  logic [31:0]      load_base,
    input  logic [LEN_W-1:0] load_len,
    input  logic             load_valid,
    input  logic [31:0]      load_data,
    output logic             load_ready,
    output logic             load_done
);
    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [LEN_W-1:0] r_remaining;
    logic             r_done;
    logic [31:0]      r_mem [DEPTH];

    logic             w_ready;
    logic             w_busy;
    logic             w_finish;
    logic             w_hs;
    logic [IDX_W-1:0] w_idx;
    logic             w_fault;
    logic             w_valid;
    logic             w_ffault;
    logic [31:0]      w_instr;
    logic             w_unused;

    // Power-up contents: all NOPs
    initial begin
        for (int i = 0; i < DEPTH; i++) r_mem[i] = NOP;
    end

    // Loader state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Loader next state; a zero-length load spends one cycle in LOAD and then completes
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (load_start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_busy  = 1'b1;
                w_ready = (r_remaining != '0);
                if (r_remaining == '0)
                    w_finish = 1'b1;
                else if (load_valid && (r_remaining == LEN_W'(1)))
                    w_finish = 1'b1;
                if (w_finish) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_hs = load_valid & w_ready;

    // Write pointer, remaining-word count and completion pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_finish;
            if ((r_state == S_IDLE) && load_start) begin
                r_ptr       <= load_base[IDX_W+1:2];
                r_remaining <= load_len;
            end else if (w_hs) begin
                r_ptr       <= r_ptr + IDX_W'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end
        end
    end

    // Memory write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_hs) r_mem[r_ptr] <= load_data;
    end

    assign w_idx    = pc[IDX_W+1:2];
    assign w_fault  = (pc[1:0] != 2'b00) | (pc[31:IDX_W+2] != '0);
    assign w_valid  = fetch_req & ~w_busy & ~w_fault;
    assign w_ffault = fetch_req & w_fault;
    assign w_instr  = w_valid ? r_mem[w_idx] : NOP;
    assign w_unused = ^{load_base[31:IDX_W+2], load_base[1:0]};

    assign busy       = w_busy;
    assign load_ready = w_ready;
    assign load_done  = r_done;

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [31:0] r_instr;
            logic        r_valid;
            logic        r_fault;

            // One-cycle fetch pipeline register; reset returns a NOP
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_instr <= NOP;
                    r_valid <= 1'b0;
                    r_fault <= 1'b0;
                end else begin
                    r_instr <= w_instr;
                    r_valid <= w_valid;
                    r_fault <= w_ffault;
                end
            end

            assign instr       = r_instr;
            assign instr_valid = r_valid;
            assign fetch_fault = r_fault;
        end else begin : g_comb
            assign instr       = w_instr;
            assign instr_valid = w_valid;
            assign fetch_fault = w_ffault;
        end
    endgenerate
endmodule
